// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decoded jump controls from `control`,
// and the instruction/PC presented back to it.
interface fetch_unit_if #(
    parameter int PC_W = 10
);
    logic            pc_reset;
    logic            pc_enable;
    logic            reljump_enable;
    logic            absjump_enable;
    logic            compare_enable;
    logic            compare_true;
    logic [7:0]      rel_offset;
    logic [PC_W-1:0] abs_target;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data;
    logic [8:0]      instruction;
    logic            instr_valid;
    logic [PC_W-1:0] pc;

    // The fetch unit drives the memory address and the instruction/PC outputs.
    modport master (
        input  pc_reset, pc_enable, reljump_enable, absjump_enable,
               compare_enable, compare_true, rel_offset, abs_target, imem_data,
        output imem_addr, instruction, instr_valid, pc
    );

    modport slave (
        output pc_reset, pc_enable, reljump_enable, absjump_enable,
               compare_enable, compare_true, rel_offset, abs_target, imem_data,
        input  imem_addr, instruction, instr_valid, pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and IDLE/FILL/RUN fetch sequencer for a synchronous-read imem.
// Optional saturating retired-instruction counter when FETCH_RETIRE_CNT_EN is defined.
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_RETIRE_CNT_EN
    output logic [31:0] retired_count,
`endif
    fetch_unit_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [PC_W-1:0]        r_pc;
    logic [PC_W-1:0]        w_next_pc;
    logic signed [PC_W-1:0] w_rel_sext;
    logic                   w_running;
    logic                   w_advance;
    logic                   w_rel_taken;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    assign w_running   = (r_state == S_RUN);
    assign w_advance   = w_running & bus.pc_enable;
    assign w_rel_taken = bus.reljump_enable & (~bus.compare_enable | bus.compare_true);
    assign w_rel_sext  = PC_W'($signed(bus.rel_offset));

    // All sums wrap modulo 2^PC_W; absolute target has priority over relative.
    always_comb begin
        w_next_pc = r_pc + PC_W'(1);
        if (bus.absjump_enable) begin
            w_next_pc = bus.abs_target;
        end else if (w_rel_taken) begin
            w_next_pc = r_pc + w_rel_sext;
        end
    end

    // Addressing the successor while retiring keeps taken jumps bubble-free.
    assign bus.imem_addr   = w_advance ? w_next_pc : r_pc;
    assign bus.pc          = r_pc;
    assign bus.instr_valid = w_running;
    assign bus.instruction = w_running ? bus.imem_data : 9'd0;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.pc_reset || !bus.pc_enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_FILL;
                S_FILL:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
        end else begin
            r_state <= w_state_nxt;
            if (bus.pc_reset) begin
                r_pc <= START_ADDR;
            end else if (w_advance) begin
                r_pc <= w_next_pc;
            end
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if (bus.pc_reset) begin
            r_retired <= 32'd0;
        end else if (w_advance) begin
            r_retired <= sat_inc32(r_retired);
        end
    end

    assign retired_count = r_retired;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: abstract PC/run-phase model checked every cycle,
// plus hand-computed literal expectations along the test-plan scenarios.
module tb_fetch_unit;

    localparam int PC_W = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [8:0] rom [1024];

    // Model state: PC, number of consecutive enabled cycles since idle (2 = running), retire count.
    int          m_pc  = 0;
    int          m_run = 0;
    int unsigned m_ret = 0;

    fetch_unit_if #(.PC_W(PC_W)) bus ();

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retired_count;
`endif

    fetch_unit #(.PC_W(PC_W), .START_ADDR('0)) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef FETCH_RETIRE_CNT_EN
        .retired_count (retired_count),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_jumps();
        bus.absjump_enable = 1'b0;
        bus.reljump_enable = 1'b0;
        bus.compare_enable = 1'b0;
        bus.compare_true   = 1'b0;
        bus.rel_offset     = 8'd0;
        bus.abs_target     = '0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_pc = 0; m_run = 0; m_ret = 0;
            end else if (bus.pc_reset) begin
                m_pc = 0; m_run = 0; m_ret = 0;
            end else if (!bus.pc_enable) begin
                m_run = 0;
            end else if (m_run < 2) begin
                m_run = m_run + 1;
            end else begin
                if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
                if (bus.absjump_enable)
                    m_pc = int'(bus.abs_target);
                else if (bus.reljump_enable && (!bus.compare_enable || bus.compare_true))
                    m_pc = (m_pc + int'($signed(bus.rel_offset))) & 1023;
                else
                    m_pc = (m_pc + 1) % 1024;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_valid", 32'(bus.instr_valid), 32'(m_run == 2));
                chk("model_pc", 32'(bus.pc), 32'(m_pc));
                chk("model_instr", 32'(bus.instruction), (m_run == 2) ? 32'(rom[m_pc]) : 32'd0);
                if (m_run < 2) chk("model_addr", 32'(bus.imem_addr), 32'(m_pc));
`ifdef FETCH_RETIRE_CNT_EN
                chk("model_retired", retired_count, m_ret);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) rom[k] = 9'(k);
        bus.pc_reset  = 1'b0;
        bus.pc_enable = 1'b0;
        clr_jumps();

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", 32'(bus.instruction), 32'h0);

        // Start latency and sequential fetch
        bus.pc_enable = 1'b1;
        tick(); chk("fill_valid", 32'(bus.instr_valid), 32'h0);
        tick(); chk("start_valid", 32'(bus.instr_valid), 32'h1);
        chk("start_pc", 32'(bus.pc), 32'h0);
        tick(); chk("seq_pc1", 32'(bus.pc), 32'h1);
        tick(); chk("seq_pc2", 32'(bus.pc), 32'h2);
        tick(); chk("seq_pc3", 32'(bus.pc), 32'h3);
        chk("seq_instr3", 32'(bus.instruction), 32'h3);

        // Absolute jump, no bubble
        bus.absjump_enable = 1'b1; bus.abs_target = 10'h040;
        tick(); chk("abs_pc", 32'(bus.pc), 32'h40);
        chk("abs_instr", 32'(bus.instruction), 32'h40);
        chk("abs_valid", 32'(bus.instr_valid), 32'h1);
        bus.abs_target = 10'h005;
        tick(); chk("abs_pc5", 32'(bus.pc), 32'h5);

        // beq not taken, then taken, then plain negative wrap
        clr_jumps();
        bus.reljump_enable = 1'b1; bus.compare_enable = 1'b1; bus.rel_offset = 8'hFD;
        tick(); chk("beq_nt_pc", 32'(bus.pc), 32'h6);
        bus.absjump_enable = 1'b1; bus.abs_target = 10'h005;
        tick(); chk("beq_back_pc", 32'(bus.pc), 32'h5);
        bus.absjump_enable = 1'b0; bus.compare_true = 1'b1;
        tick(); chk("beq_t_pc", 32'(bus.pc), 32'h2);
        bus.compare_enable = 1'b0; bus.compare_true = 1'b0; bus.rel_offset = 8'hF8;
        tick(); chk("rel_wrap_pc", 32'(bus.pc), 32'h3FA);
        chk("rel_wrap_instr", 32'(bus.instruction), 32'h1FA);

        // Absolute beats relative
        bus.absjump_enable = 1'b1; bus.abs_target = 10'h007; bus.rel_offset = 8'h05;
        tick(); chk("abs_prio_pc", 32'(bus.pc), 32'h7);

        // Stall for 3 cycles with jump requests that must be ignored
        bus.pc_enable = 1'b0; bus.abs_target = 10'h055;
        tick(); chk("stall_valid", 32'(bus.instr_valid), 32'h0);
        chk("stall_pc", 32'(bus.pc), 32'h7);
        chk("stall_instr", 32'(bus.instruction), 32'h0);
        tick(); tick();
        bus.pc_enable = 1'b1; clr_jumps();
        tick(); chk("reen_fill_valid", 32'(bus.instr_valid), 32'h0);
        tick(); chk("reen_valid", 32'(bus.instr_valid), 32'h1);
        chk("reen_pc", 32'(bus.pc), 32'h7);
        chk("reen_instr", 32'(bus.instruction), 32'h7);

        // pc_reset mid-RUN, and pc_reset beating pc_enable
        bus.absjump_enable = 1'b1; bus.abs_target = 10'h123;
        tick(); chk("pre_prst_pc", 32'(bus.pc), 32'h123);
        clr_jumps(); bus.pc_reset = 1'b1;
        tick(); chk("prst_pc", 32'(bus.pc), 32'h0);
        chk("prst_valid", 32'(bus.instr_valid), 32'h0);
        tick(); chk("prst_hold_valid", 32'(bus.instr_valid), 32'h0);
        bus.pc_reset = 1'b0;
        tick(); chk("prst_fill_valid", 32'(bus.instr_valid), 32'h0);
        tick(); chk("prst_run_valid", 32'(bus.instr_valid), 32'h1);

        // PC wrap at the top of the address space
        bus.absjump_enable = 1'b1; bus.abs_target = 10'h3FF;
        tick(); chk("top_pc", 32'(bus.pc), 32'h3FF);
        chk("top_instr", 32'(bus.instruction), 32'h1FF);
        clr_jumps();
        tick(); chk("wrap_pc", 32'(bus.pc), 32'h0);
        chk("wrap_instr", 32'(bus.instruction), 32'h0);

        // Asynchronous reset mid-RUN
        tick(); tick();
        chk("pre_arst_pc", 32'(bus.pc), 32'h2);
        reset = 1'b1; bus.pc_enable = 1'b0;
        #1;
        chk("arst_pc", 32'(bus.pc), 32'h0);
        chk("arst_valid", 32'(bus.instr_valid), 32'h0);
        chk("arst_instr", 32'(bus.instruction), 32'h0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("arst_idle_valid", 32'(bus.instr_valid), 32'h0);

        // Run 10 instructions, stall 2 cycles, then pc_reset
        bus.pc_enable = 1'b1;
        tick(); tick();
        repeat (10) tick();
        chk("run10_pc", 32'(bus.pc), 32'hA);
        bus.pc_enable = 1'b0;
        tick(); tick();
`ifdef FETCH_RETIRE_CNT_EN
        chk("ret_after_stall", retired_count, 32'd10);
`endif
        bus.pc_reset = 1'b1;
        tick();
`ifdef FETCH_RETIRE_CNT_EN
        chk("ret_after_prst", retired_count, 32'd0);
`endif
        chk("final_pc", 32'(bus.pc), 32'h0);
        bus.pc_reset = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
